// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply controller.
package mips_pkg;

  localparam int MULT_LATENCY = 4;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MFHI  = 3'd2,
    OP_MFLO  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mult_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } mult_state_t;

  function automatic logic op_is_mul(input mult_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // HI/LO moves must wait for every in-flight product to retire.
  function automatic logic op_is_move(input mult_op_t op);
    return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Magnitude of a 32-bit two's-complement value; 0x80000000 stays 0x80000000,
  // which the unsigned multiplier reads as 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_mult_sign_q.sv
// Result-sign shift queue: one bit enters per cycle and leaves DEPTH cycles
// later, lining up with the matching product at the multiplier output.
module mips_mult_sign_q #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_sign,
  output logic pop_sign
);

  logic [DEPTH-1:0] sq_q, sq_d;

  // Shift by one stage every cycle; idle cycles push 0.
  always_comb begin
    sq_d    = sq_q;
    sq_d[0] = push_sign;
    for (int i = 1; i < DEPTH; i++) sq_d[i] = sq_q[i-1];
  end

  // Queue register, cleared with the multiplier it shadows.
  always_ff @(posedge clk) begin
    if (rst) sq_q <= '0;
    else     sq_q <= sq_d;
  end

  assign pop_sign = sq_q[DEPTH-1];

endmodule

// File: rtl/mips_mult_ctrl.sv
// MIPS multiply/HI-LO controller in front of a LATENCY-stage pipelined multiplier.
// Optional: MIPS_MULT_SIGNED_EN makes MULT signed (magnitude issue + sign queue).
module mips_mult_ctrl
  import mips_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  mult_op_t    req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        mul_start,
  output logic [31:0] mul_src_a,
  output logic [31:0] mul_src_b,
  input  logic        mul_done,
  input  logic [31:0] mul_lower,
  input  logic [31:0] mul_higher,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  mult_state_t state_q, state_d;
  logic [3:0]  inflight_q, inflight_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic        is_mul, is_move, accept, full, issue, overflow;
  logic        done_ok, spurious;
  logic [63:0] prod;

  assign is_mul  = op_is_mul(req_op);
  assign is_move = op_is_move(req_op);

  // Handshake: multiplies stream unless draining; moves wait for an empty pipe.
  // Unrecognised opcodes are accepted and dropped so the stage never locks up.
  always_comb begin
    req_ready = 1'b1;
    if (is_mul)       req_ready = (state_q != ST_DRAIN);
    else if (is_move) req_ready = (inflight_q == 4'd0) && !mul_done;
  end

  assign accept   = req_valid && req_ready;
  // A retire in the same cycle frees a slot, so only a stall-free full pipe blocks.
  assign full     = (inflight_q == LAT4) && !mul_done;
  assign issue    = accept && is_mul && !full;
  assign overflow = accept && is_mul && full;
  assign done_ok  = mul_done && (inflight_q != 4'd0);
  assign spurious = mul_done && (inflight_q == 4'd0);

  assign mul_start = issue;

`ifdef MIPS_MULT_SIGNED_EN
  logic signed_op, push_sign, pop_sign;

  assign signed_op = (req_op == OP_MULT);
  assign mul_src_a = signed_op ? mag32(req_a) : req_a;
  assign mul_src_b = signed_op ? mag32(req_b) : req_b;
  assign push_sign = issue && signed_op && (req_a[31] ^ req_b[31]);

  mips_mult_sign_q #(.DEPTH(LATENCY)) u_sign_q (
    .clk       (clk),
    .rst       (rst),
    .push_sign (push_sign),
    .pop_sign  (pop_sign)
  );

  // Restore the sign of the retiring product.
  always_comb begin
    prod = {mul_higher, mul_lower};
    if (pop_sign) prod = ~prod + 64'd1;
  end
`else
  assign mul_src_a = req_a;
  assign mul_src_b = req_b;

  // MULT and MULTU share the unsigned product.
  always_comb begin
    prod = {mul_higher, mul_lower};
  end
`endif

  // In-flight count, HI/LO, move results and sticky error.
  always_comb begin
    inflight_d = inflight_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q | spurious | overflow;

    case ({issue, done_ok})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    if (done_ok) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end else if (accept && (req_op == OP_MTHI)) begin
      hi_d = req_a;
    end else if (accept && (req_op == OP_MTLO)) begin
      lo_d = req_a;
    end

    if (accept && (req_op == OP_MFHI)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hi_q;
    end else if (accept && (req_op == OP_MFLO)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = lo_q;
    end
  end

  // Next-state logic: DRAIN blocks new multiplies until a pending move can go.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (issue) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (inflight_d == 4'd0)          state_d = ST_IDLE;
        else if (req_valid && is_move)   state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (inflight_d == 4'd0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 4'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign busy     = (inflight_q != 4'd0);

endmodule

// File: tb/tb_mips_mult_ctrl.sv
// Self-checking bench for mips_mult_ctrl with a behavioural pipelined multiplier.
module tb_mips_mult_ctrl;
  import mips_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rd_valid, mul_start, mul_done, busy, err;
  mult_op_t    req_op;
  logic [31:0] req_a, req_b, rd_data, mul_src_a, mul_src_b, mul_lower, mul_higher, hi, lo;
  logic        force_done;

  always #5 clk = ~clk;

  mips_mult_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .mul_start(mul_start), .mul_src_a(mul_src_a), .mul_src_b(mul_src_b),
    .mul_done(mul_done), .mul_lower(mul_lower), .mul_higher(mul_higher),
    .hi(hi), .lo(lo), .busy(busy), .err(err)
  );

  // Unsigned pipelined multiplier model: done LAT cycles after start.
  logic [LAT-1:0] pv;
  logic [63:0]    pp [LAT];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], mul_start};
    for (int i = LAT-1; i > 0; i--) pp[i] <= pp[i-1];
    pp[0] <= {32'd0, mul_src_a} * {32'd0, mul_src_b};
  end
  assign mul_done = pv[LAT-1] | force_done;
  assign {mul_higher, mul_lower} = force_done ? 64'hDEADBEEF_CAFEF00D : pp[LAT-1];

  int          n_chk = 0, n_err = 0, peak = 0;
  logic [63:0] prod_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: HI/LO checked one edge after an in-flight mul_done; rd results checked.
  initial begin
    logic        pend;
    logic [63:0] e;
    logic [31:0] r;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("prod_expected", 64'(prod_q.size() != 0), 64'd1);
        if (prod_q.size() != 0) begin
          e = prod_q.pop_front();
          chk("hi", 64'(hi), 64'(e[63:32]));
          chk("lo", 64'(lo), 64'(e[31:0]));
          m_hi = e[63:32];
          m_lo = e[31:0];
        end
      end
      pend = mul_done && busy && !rst;
      if (rd_valid) begin
        chk("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(r));
        end
      end
      if (int'(dut.inflight_q) > peak) peak = int'(dut.inflight_q);
    end
  end

  // Drive one request and hold it until accepted; expectations pushed on acceptance.
  task automatic issue(input mult_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    bit          ok;
    logic [63:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    stalls = 0; ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        case (op)
          OP_MULT: begin
`ifdef MIPS_MULT_SIGNED_EN
            e = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`else
            e = {32'd0, a} * {32'd0, b};
`endif
            prod_q.push_back(e);
          end
          OP_MULTU: begin
            e = {32'd0, a} * {32'd0, b};
            prod_q.push_back(e);
          end
          OP_MFHI: rd_q.push_back(m_hi);
          OP_MFLO: rd_q.push_back(m_lo);
          OP_MTHI: m_hi = a;
          OP_MTLO: m_lo = a;
          default: ;
        endcase
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    chk("ready_timeout", 64'(ok), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    bit q;
    q = 1'b0;
    for (int t = 0; t < 60 && !q; t++) begin
      @(negedge clk);
      #1;
      q = !busy;
    end
    chk("quiet_timeout", 64'(q), 64'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    prod_q.delete(); rd_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    rst = 1'b1; req_valid = 1'b0; req_op = OP_MULTU; req_a = 32'd0; req_b = 32'd0;
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_ready_mul", 64'(req_ready), 64'd1);

    // MULTU max x max
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    idle();
    wait_quiet();
    chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_max_lo", 64'(lo), 64'h00000001);

    // MULT -3 x 7
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, st);
    idle();
    wait_quiet();
`ifdef MIPS_MULT_SIGNED_EN
    chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
`else
    chk("mult_neg_hi", 64'(hi), 64'h00000006);
`endif
    chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

    // Four back-to-back MULTU
    peak = 0; tot = 0;
    issue(OP_MULTU, 32'd2, 32'd3, st); tot += st;
    issue(OP_MULTU, 32'd4, 32'd5, st); tot += st;
    issue(OP_MULTU, 32'd6, 32'd7, st); tot += st;
    issue(OP_MULTU, 32'd8, 32'd9, st); tot += st;
    idle();
    wait_quiet();
    chk("b2b_stalls", 64'(tot), 64'd0);
    chk("b2b_peak", 64'(peak), 64'd4);
    chk("b2b_last_lo", 64'(lo), 64'd72);

    // MFLO right behind MULTU: blocked, DRAIN, then reads the product
    issue(OP_MULTU, 32'd10, 32'd10, st);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MFLO; req_a = 32'd0; req_b = 32'd0;
    #1;
    chk("mflo_blocked", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("mflo_drain", 64'(dut.state_q), 64'(ST_DRAIN));
    chk("mflo_busy", 64'(busy), 64'd1);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    chk("mflo_stalled", 64'(st > 0), 64'd1);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("mflo_rd_100", 64'(rd_data), 64'd100);

    // Moves to and from HI/LO
    issue(OP_MTHI, 32'h12345678, 32'd0, st);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0, st);
    issue(OP_MFHI, 32'd0, 32'd0, st);
    issue(OP_MFLO, 32'd0, 32'd0, st);
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("mt_hi", 64'(hi), 64'h12345678);
    chk("mt_lo", 64'(lo), 64'h9ABCDEF0);
    chk("mf_last_rd", 64'(rd_data), 64'h9ABCDEF0);

    // Reset two cycles after a MULTU issue discards the product
    issue(OP_MULTU, 32'd5, 32'd5, st);
    idle();
    do_reset();
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_inflight", 64'(dut.inflight_q), 64'd0);
    repeat (LAT + 2) @(negedge clk);
    #1;
    chk("midrst_hi_late", 64'(hi), 64'd0);
    chk("midrst_lo_late", 64'(lo), 64'd0);

    // Spurious mul_done: err sticks, HI/LO untouched until reset
    issue(OP_MTHI, 32'h11112222, 32'd0, st);
    issue(OP_MTLO, 32'h33334444, 32'd0, st);
    idle();
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    #1;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_hi", 64'(hi), 64'h11112222);
    chk("spur_lo", 64'(lo), 64'h33334444);
    repeat (3) @(negedge clk);
    #1;
    chk("spur_err_sticky", 64'(err), 64'd1);
    chk("spur_hi_late", 64'(hi), 64'h11112222);
    do_reset();
    chk("spur_err_cleared", 64'(err), 64'd0);

    chk("prod_drained", 64'(prod_q.size()), 64'd0);
    chk("rd_drained", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mult_ctrl.md
MIPS_MULT_CTRL -- requirements
Module: mips_mult_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: multiplier start-to-done cycles, legal range 1..8.
REQ-002 SHALL have ports in this order:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
REQ-003 SHALL have port req_valid  in  1  request from execute stage.
REQ-004 SHALL have port req_op  in  3  mult_op_t: MULT, MULTU, MFHI, MFLO, MTHI, MTLO.
REQ-005 SHALL have port req_a, req_b  in  32 each  rs and rt operands.
REQ-006 SHALL have port req_ready  out  1  request accepted this cycle when req_valid=1.
REQ-007 SHALL have port rd_valid, rd_data  out  1 and 32  MFHI/MFLO result.
REQ-008 SHALL have port mul_start, mul_src_a, mul_src_b  out  1, 32, 32  drive to the pipelined multiplier.
REQ-009 SHALL have port mul_done, mul_lower, mul_higher  in  1, 32, 32  returns from the multiplier.
REQ-010 SHALL have port hi, lo  out  32 each  architectural HI/LO registers.
REQ-011 SHALL have port busy  out  1  inflight≠0.
REQ-012 SHALL have port err  out  1  sticky protocol error.

Function
REQ-013 SHALL assert req_ready combinationally for MULT/MULTU whenever state≠DRAIN, enabling one issue per cycle (back-to-back).
REQ-014 SHALL assert mul_start in the acceptance cycle of a MULT/MULTU and drive mul_src_a/b in that same cycle (combinational pass-through); mul_start=0 otherwise.
REQ-015 SHALL keep a 4-bit inflight counter: +1 on issue, −1 on mul_done, unchanged when both occur in one cycle.
REQ-016 SHALL, on mul_done, load lo←mul_lower and hi←mul_higher (sign-corrected per REQ-024) at the next edge, in issue order.
REQ-017 SHALL implement FSM IDLE/ACTIVE/DRAIN:
- IDLE→ACTIVE on issue.
- ACTIVE→IDLE when inflight reaches 0.
- ACTIVE→DRAIN when an MFHI/MFLO/MTHI/MTLO arrives with inflight≠0.
- DRAIN→IDLE when inflight reaches 0.
REQ-018 SHALL hold req_ready=0 for MFHI/MFLO/MTHI/MTLO while inflight≠0 or mul_done=1, and also for MULT/MULTU while in DRAIN.
REQ-019 SHALL, on accepted MFHI/MFLO, register rd_data←hi/lo and pulse rd_valid one cycle later.
REQ-020 SHALL, on accepted MTHI/MTLO, write req_a to hi/lo at the next edge.
REQ-021 SHALL, if mul_done arrives with inflight=0, ignore the data, leave HI/LO unchanged and set err until reset.
REQ-022 SHALL never let inflight exceed LATENCY; an issue that would exceed it sets err.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, including mid-operation, set:
- state=IDLE
- inflight=0
- hi=lo=0
- rd_valid=0, rd_data=0
- err=0
- sign queue cleared
The multiplier shares rst, so in-flight products are discarded.

Configuration
REQ-024 SHALL, with MIPS_MULT_SIGNED_EN defined, handle MULT operands signed:
- Issue magnitudes |a|, |b|; 0x80000000 maps to 2^31 unsigned.
- Push sign a[31]^b[31] into a LATENCY-deep shift queue aligned with the pipeline.
- Two's-complement negate the 64-bit product on mul_done when the popped sign=1.
- MULTU pushes 0.
REQ-025 SHALL, without MIPS_MULT_SIGNED_EN, treat MULT identically to MULTU and omit the sign queue.

Structure
REQ-026 SHALL take mult_op_t and localparam MULT_LATENCY=4 from mips_pkg.
REQ-027 SHALL place the sign queue in sub-module mips_mult_sign_q (LATENCY-deep shift register, synchronous reset).
REQ-028 SHALL use no additional sub-modules; the FSM and counter stay in the top.

Verification
REQ-029 SHALL cover: MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 one edge after mul_done.
REQ-030 SHALL cover: MULT −3×7 with _EN -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; without _EN -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-031 SHALL cover: 4 back-to-back MULTU (2×3, 4×5, 6×7, 8×9) -> req_ready stays 1, lo sequence 6,20,42,72, inflight peaks at 4.
REQ-032 SHALL cover: MFLO issued 1 cycle after MULTU 10×10 -> req_ready=0 and state DRAIN until done, then rd_valid with rd_data=100.
REQ-033 SHALL cover: rst asserted 2 cycles after MULTU issue -> hi=lo=0, inflight=0, busy=0, no later HI/LO update.
REQ-034 SHALL cover: mul_done forced with inflight=0 -> err=1, HI/LO unchanged until reset.
